// File: rtl/alu_nibble_seq_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer:
// op encodings, sequencer states and the nibble size.
package alu_nibble_seq_pkg;

    localparam int NIBBLE = 4;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } seq_state_e;

    // Index counter width for a WIDTH-bit operand, never narrower than one bit.
    function automatic int idx_width(input int width);
        return (width / NIBBLE > 1) ? $clog2(width / NIBBLE) : 1;
    endfunction

endpackage

// File: rtl/alu_nibble_seq_adder_4bit.sv
// The existing 4-bit adder datapath that the sequencer time-shares
// across every nibble of an operation.
module adder_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

endmodule

// File: rtl/alu_nibble_seq.sv
// Multi-nibble add/subtract sequencer: one nibble per clock, LSB first,
// through a single shared 4-bit adder with a registered carry chain.
module alu_nibble_seq
    import alu_nibble_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int NUM_NIB = WIDTH / NIBBLE;
    localparam int IDX_W   = idx_width(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NIB - 1);

    seq_state_e state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_out_q, carry_out_d;
    logic             overflow_q, overflow_d;
    logic             zero_q, zero_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [NIBBLE-1:0] nib_a;
    logic [NIBBLE-1:0] nib_b;
    logic [NIBBLE-1:0] nib_sum;
    logic              nib_cout;

    // Subtract reuses the adder: invert B here, the +1 comes from the carry seed.
    assign nib_a = a_q[NIBBLE*idx_q +: NIBBLE];
    assign nib_b = b_q[NIBBLE*idx_q +: NIBBLE] ^ {NIBBLE{op_q}};

    adder_4bit u_adder (
        .a   (nib_a),
        .b   (nib_b),
        .cin (carry_q),
        .sum (nib_sum),
        .cout(nib_cout)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;
        zero_d      = zero_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d        = a;
                    b_d        = b;
                    op_d       = op;
                    idx_d      = '0;
                    carry_d    = op;
                    in_ready_d = 1'b0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                result_d[NIBBLE*idx_q +: NIBBLE] = nib_sum;
                carry_d = nib_cout;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    // Flags are latched here so they stay frozen for the whole DONE phase.
                    idx_d       = '0;
                    carry_out_d = nib_cout;
                    if (op_q == OP_ADD)
                        overflow_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                     (nib_sum[NIBBLE-1] != a_q[WIDTH-1]);
                    else
                        overflow_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                                     (nib_sum[NIBBLE-1] != a_q[WIDTH-1]);
                    zero_d      = (result_d == '0);
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            op_q        <= OP_ADD;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Bench for alu_nibble_seq: directed vectors and corner sequences at WIDTH=16,
// randomized sweeps at WIDTH=8 and WIDTH=32 against an arithmetic reference model.
module tb_alu_nibble_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   applied = 0;
    int   miscompares = 0;

    logic in_valid_v [3];
    logic out_ready_v[3];
    logic op_v       [3];
    logic in_ready_v [3];
    logic out_valid_v[3];
    logic co_v       [3];
    logic ov_v       [3];
    logic zr_v       [3];

    logic [15:0] a16, b16, res16;
    logic [7:0]  a8,  b8,  res8;
    logic [31:0] a32, b32, res32;

    alu_nibble_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .op(op_v[0]), .a(a16), .b(b16), .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
        .result(res16), .carry_out(co_v[0]), .overflow(ov_v[0]), .zero(zr_v[0])
    );

    alu_nibble_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .op(op_v[1]), .a(a8), .b(b8), .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
        .result(res8), .carry_out(co_v[1]), .overflow(ov_v[1]), .zero(zr_v[1])
    );

    alu_nibble_seq #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
        .op(op_v[2]), .a(a32), .b(b32), .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
        .result(res32), .carry_out(co_v[2]), .overflow(ov_v[2]), .zero(zr_v[2])
    );

    typedef struct {
        logic        op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        co;
        logic        ov;
        logic        zr;
    } vec_t;

    function automatic int width_of(input int i);
        case (i)
            0:       return 16;
            1:       return 8;
            default: return 32;
        endcase
    endfunction

    function automatic logic [31:0] get_res(input int i);
        case (i)
            0:       return {16'h0000, res16};
            1:       return {24'h000000, res8};
            default: return res32;
        endcase
    endfunction

    task automatic set_ops(input int i, input logic [31:0] av, input logic [31:0] bv);
        case (i)
            0:       begin a16 = av[15:0]; b16 = bv[15:0]; end
            1:       begin a8  = av[7:0];  b8  = bv[7:0];  end
            default: begin a32 = av;       b32 = bv;       end
        endcase
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the numeric operand values.
    function automatic void model(input int w, input logic opv, input logic [31:0] av,
                                  input logic [31:0] bv, output logic [31:0] r,
                                  output logic co, output logic ov, output logic zr);
        longint lim, modv, ua, ub, sa, sb, u, s;
        lim  = longint'(1) <<< (w - 1);
        modv = lim * 2;
        ua   = longint'({32'h0, av}) % modv;
        ub   = longint'({32'h0, bv}) % modv;
        sa   = (ua >= lim) ? ua - modv : ua;
        sb   = (ub >= lim) ? ub - modv : ub;
        if (opv == 1'b0) begin
            u  = ua + ub;
            co = (u >= modv);
            s  = sa + sb;
        end else begin
            u  = ua - ub;
            co = (ua >= ub);
            s  = sa - sb;
        end
        if (u < 0) u = u + modv;
        r  = 32'(u % modv);
        ov = (s >= lim) || (s < -lim);
        zr = (r == 32'h0);
    endfunction

    // One complete transaction: issue, wait for the result, optionally stall, then drain.
    task automatic do_op(input int i, input logic opv, input logic [31:0] av, input logic [31:0] bv,
                         input int hold, input bit noise, output logic [31:0] r,
                         output logic co, output logic ov, output logic zr,
                         output int lat, output bit stable);
        int n;
        n = 0;
        @(negedge clk);
        op_v[i] = opv;
        set_ops(i, av, bv);
        in_valid_v[i] = 1'b1;
        while (!in_ready_v[i] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check($sformatf("w%0d_accept_timeout", width_of(i)), 32'(in_ready_v[i]), 32'h1);
        @(negedge clk);
        lat = 1;
        in_valid_v[i] = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        op_v[i] = 1'($urandom_range(0, 1));
        set_ops(i, $urandom, $urandom);
        while (!out_valid_v[i] && lat < 200) begin
            @(negedge clk);
            lat++;
            if (noise) in_valid_v[i] = 1'($urandom_range(0, 1));
            set_ops(i, $urandom, $urandom);
        end
        r  = get_res(i);
        co = co_v[i];
        ov = ov_v[i];
        zr = zr_v[i];
        stable = 1'b1;
        repeat (hold) begin
            @(negedge clk);
            if (noise) in_valid_v[i] = 1'($urandom_range(0, 1));
            if (get_res(i) !== r || co_v[i] !== co || ov_v[i] !== ov || zr_v[i] !== zr ||
                in_ready_v[i] !== 1'b0 || out_valid_v[i] !== 1'b1)
                stable = 1'b0;
        end
        in_valid_v[i]  = 1'b0;
        out_ready_v[i] = 1'b1;
        @(negedge clk);
        out_ready_v[i] = 1'b0;
        check($sformatf("w%0d_in_ready_after_handshake", width_of(i)), 32'(in_ready_v[i]), 32'h1);
        check($sformatf("w%0d_out_valid_after_handshake", width_of(i)), 32'(out_valid_v[i]), 32'h0);
    endtask

    task automatic random_sweep(input int i, input int count);
        int          w, lat;
        logic [31:0] mask, av, bv, r, er;
        logic        opv, co, ov, zr, eco, eov, ezr;
        bit          stable;
        w    = width_of(i);
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        for (int k = 0; k < count; k++) begin
            opv = 1'($urandom_range(0, 1));
            av  = $urandom & mask;
            bv  = $urandom & mask;
            case ($urandom_range(0, 7))
                0:       av = mask;
                1:       bv = 32'h1 << (w - 1);
                2:       bv = av;
                default: ;
            endcase
            do_op(i, opv, av, bv, $urandom_range(0, 3), 1'b1, r, co, ov, zr, lat, stable);
            model(w, opv, av, bv, er, eco, eov, ezr);
            check($sformatf("w%0d_result", w),   r,       er);
            check($sformatf("w%0d_carry", w),    32'(co), 32'(eco));
            check($sformatf("w%0d_overflow", w), 32'(ov), 32'(eov));
            check($sformatf("w%0d_zero", w),     32'(zr), 32'(ezr));
            check($sformatf("w%0d_latency", w),  32'(lat), 32'(w / 4 + 1));
            check($sformatf("w%0d_stall_stable", w), 32'(stable), 32'h1);
        end
    endtask

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t        vecs[8];
        logic [31:0] r;
        logic        co, ov, zr;
        int          lat, cnt;
        bit          stable;

        vecs[0] = '{1'b0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 16'h0007, 16'h0005, 16'h0002, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1, 1'b1};

        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid_v[i]  = 1'b0;
            out_ready_v[i] = 1'b0;
            op_v[i]        = 1'b0;
            set_ops(i, 32'h0, 32'h0);
        end
        #12;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset_in_ready_%0d", i),  32'(in_ready_v[i]),  32'h1);
            check($sformatf("reset_out_valid_%0d", i), 32'(out_valid_v[i]), 32'h0);
            check($sformatf("reset_result_%0d", i),    get_res(i),          32'h0);
            check($sformatf("reset_flags_%0d", i),     {29'h0, co_v[i], ov_v[i], zr_v[i]}, 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 8; v++) begin
            do_op(0, vecs[v].op, 32'(vecs[v].a), 32'(vecs[v].b), v % 2, 1'b0, r, co, ov, zr, lat, stable);
            check($sformatf("vec%0d_result", v),   r,        32'(vecs[v].res));
            check($sformatf("vec%0d_carry", v),    32'(co),  32'(vecs[v].co));
            check($sformatf("vec%0d_overflow", v), 32'(ov),  32'(vecs[v].ov));
            check($sformatf("vec%0d_zero", v),     32'(zr),  32'(vecs[v].zr));
            check($sformatf("vec%0d_latency", v),  32'(lat), 32'd5);
        end

        // Backpressure: 10 stalled cycles with in_valid noise in RUN and DONE.
        do_op(0, 1'b0, 32'h0000_1234, 32'h0000_0FFF, 10, 1'b1, r, co, ov, zr, lat, stable);
        check("bp_result", r, 32'h2233);
        check("bp_stable", 32'(stable), 32'h1);
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid_v[0] !== 1'b0 || in_ready_v[0] !== 1'b1) cnt++;
        end
        check("bp_no_queued_op", 32'(cnt), 32'h0);

        // Asynchronous reset in the middle of RUN, after the first carry was registered.
        @(negedge clk);
        a16 = 16'hFFFF; b16 = 16'h0001; op_v[0] = 1'b0; in_valid_v[0] = 1'b1;
        check("mid_reset_ready_before", 32'(in_ready_v[0]), 32'h1);
        @(negedge clk);
        in_valid_v[0] = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_reset_in_ready",  32'(in_ready_v[0]),  32'h1);
        check("mid_reset_out_valid", 32'(out_valid_v[0]), 32'h0);
        check("mid_reset_result",    get_res(0),          32'h0);
        check("mid_reset_flags",     {29'h0, co_v[0], ov_v[0], zr_v[0]}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(0, 1'b0, 32'h1, 32'h1, 0, 1'b0, r, co, ov, zr, lat, stable);
        check("post_reset_result", r, 32'h2);
        check("post_reset_flags",  {29'h0, co, ov, zr}, 32'h0);

        // Back-to-back issue with out_ready tied high.
        @(negedge clk);
        out_ready_v[0] = 1'b1;
        a16 = 16'h0003; b16 = 16'h0004; op_v[0] = 1'b0; in_valid_v[0] = 1'b1;
        check("b2b_first_ready", 32'(in_ready_v[0]), 32'h1);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!in_ready_v[0] && cnt < 20);
        check("b2b_interval", 32'(cnt), 32'd6);
        @(negedge clk);
        in_valid_v[0] = 1'b0;
        cnt = 0;
        while (!out_valid_v[0] && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check("b2b_second_result", get_res(0), 32'h7);
        @(negedge clk);
        out_ready_v[0] = 1'b0;

        fork
            random_sweep(1, 1000);
            random_sweep(2, 1000);
        join

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_nibble_seq.md
# alu_nibble_seq

Multi-nibble add/subtract sequencer that time-shares one 4-bit adder across a WIDTH-bit operation. It accepts a full-width operand pair over a valid/ready handshake and processes one nibble per clock, LSB first, chaining the carry through a register. It presents the result with carry, signed-overflow and zero flags on an output handshake. It sits between the ALU command front end and the existing 4-bit adder/subtract datapath.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  operation request valid.
- in_ready  output  1  sequencer can accept a request.
- op  input  1  0 = add (a+b), 1 = subtract (a-b).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  sum or difference.
- carry_out  output  1  add: carry out of bit WIDTH-1; subtract: 1 = no borrow (a >= b unsigned).
- overflow  output  1  two's-complement signed overflow.
- zero  output  1  result == 0.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. When in_valid && in_ready:
  - register a, b and op;
  - clear the nibble index;
  - initialise the carry register to op (1 for subtract, so ~b+1 forms the two's complement);
  - go to RUN.
- RUN: in_ready=0. Each cycle:
  - drive the adder with nibble[idx] of a, nibble[idx] of b (inverted when op=1) and the carry register;
  - write the adder sum into result nibble[idx];
  - load the carry register with the adder carry_out;
  - increment idx.
  - When idx == WIDTH/4-1 is processed, go to DONE.
- DONE: out_valid=1. result and the flags are stable and held while out_ready=0. When out_valid && out_ready, go to IDLE.
- carry_out is the carry register value after the final nibble.
- overflow is computed from the sign bits of a, b and result:
  - add: a[W-1]==b[W-1] && result[W-1]!=a[W-1];
  - subtract: a[W-1]!=b[W-1] && result[W-1]!=a[W-1].
- zero = (result == 0), registered on entry to DONE.
- Inputs a, b and op are sampled only at acceptance. Changes afterwards have no effect.
- in_valid outside IDLE is ignored (not queued).
- Reset, asserted at any time including mid-RUN or in DONE, forces:
  - state IDLE, idx 0, carry register 0;
  - result 0, carry_out 0, overflow 0, zero 0;
  - out_valid 0, in_ready 1.
- A pending operation is discarded; no partial result is ever presented.

## Timing
- Reset values: in_ready=1, out_valid=0, result=0, carry_out=0, overflow=0, zero=0.
- The acceptance edge is cycle 0. RUN occupies cycles 1..WIDTH/4. out_valid is high from cycle WIDTH/4+1, so the latency is WIDTH/4+1 cycles (5 for WIDTH=16).
- out_valid stays high until the handshake completes. in_ready rises in the cycle after the out_ready handshake.
- No overlap: the earliest back-to-back issue interval is WIDTH/4+2 cycles with out_ready tied high.
- Outputs are registered; there is no combinational path from in_valid/out_ready to in_ready/out_valid.

## Structure
- Shared ALU package:
  - the op encoding constants OP_ADD=0 and OP_SUB=1;
  - the sequencer state enum (IDLE, RUN, DONE);
  - the NIBBLE=4 constant.
- One sub-module: a single instance of the existing adder_4bit. B inversion is done in the sequencer, so subtract shares the same adder instance. Do not instantiate a second adder.
- The index counter width is clog2(WIDTH/4), minimum 1 bit.

## Test plan
- Add, WIDTH=16: a=0x1234, b=0x0FFF, op=0 -> result=0x2233, carry_out=0, overflow=0, zero=0; out_valid exactly 5 cycles after acceptance.
- Subtract with borrow: a=0x0005, b=0x0007, op=1 -> result=0xFFFE, carry_out=0, overflow=0; then a=0x0007, b=0x0005 -> 0x0002, carry_out=1.
- Flags: 0x7FFF+0x0001 -> 0x8000, overflow=1; 0xFFFF+0x0001 -> 0x0000, carry_out=1, zero=1; 0x8000-0x0001 -> 0x7FFF, overflow=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> result and flags are stable and in_ready=0 throughout; in_valid pulses during RUN/DONE are ignored; release -> in_ready=1 on the next cycle.
- Reset mid-operation: assert rst_n=0 asynchronously in RUN cycle 2 -> all outputs at reset values immediately; after release a new add 0x0001+0x0001 returns 0x0002 with no residual carry.
- Parameter sweep: WIDTH=8 and WIDTH=32 with random a, b, op (1000 ops each, random out_ready) -> matches the reference model for result, carry_out, overflow and zero; latency is WIDTH/4+1.
